// File: rtl/alu_op_sequencer_if.sv
// Signal bundle for alu_op_sequencer: operand stream, ALU drive/return and result stream.
// out_zero exists only when ALU_SEQ_ZERO_FLAG_EN is defined.
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_s;
    logic [WIDTH-1:0] alu_y;
    logic             alu_carry;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_s;
    logic [WIDTH-1:0] out_y;
    logic             out_carry;
    logic             out_last;
    logic             busy;

`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             out_zero;

    modport master (
        input  in_valid, in_a, in_b, alu_y, alu_carry, out_ready,
        output in_ready, alu_a, alu_b, alu_s, out_valid, out_s, out_y,
               out_carry, out_last, busy, out_zero
    );

    modport slave (
        output in_valid, in_a, in_b, alu_y, alu_carry, out_ready,
        input  in_ready, alu_a, alu_b, alu_s, out_valid, out_s, out_y,
               out_carry, out_last, busy, out_zero
    );
`else
    modport master (
        input  in_valid, in_a, in_b, alu_y, alu_carry, out_ready,
        output in_ready, alu_a, alu_b, alu_s, out_valid, out_s, out_y,
               out_carry, out_last, busy
    );

    modport slave (
        output in_valid, in_a, in_b, alu_y, alu_carry, out_ready,
        input  in_ready, alu_a, alu_b, alu_s, out_valid, out_s, out_y,
               out_carry, out_last, busy
    );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Sweeps a combinational ALU through OP_FIRST..OP_LAST for one operand pair, one result beat per opcode.
// Optional out_zero flag is enabled by defining ALU_SEQ_ZERO_FLAG_EN.
module alu_op_sequencer #(
    parameter int WIDTH    = 8,
    parameter int OP_FIRST = 0,
    parameter int OP_LAST  = 7,
    parameter int SETTLE   = 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_op_sequencer_if.master bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_OUT    = 2'd2;

    localparam logic [2:0] S_FIRST  = 3'(OP_FIRST);
    localparam logic [2:0] S_LAST   = 3'(OP_LAST);
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    logic [1:0]       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_s_q, alu_s_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       out_s_q, out_s_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_carry_q, out_carry_d;
    logic             out_last_q, out_last_d;
    logic             in_ready;
`ifdef ALU_SEQ_ZERO_FLAG_EN
    logic             out_zero_q, out_zero_d;
`endif

    // Ready is gated by rst_n so nothing is offered while the block is held in reset.
    assign in_ready = rst_n && (state_q == ST_IDLE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        out_valid_d = out_valid_q;
        out_s_d     = out_s_q;
        out_y_d     = out_y_q;
        out_carry_d = out_carry_q;
        out_last_d  = out_last_q;
`ifdef ALU_SEQ_ZERO_FLAG_EN
        out_zero_d  = out_zero_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready) begin
                    alu_a_d = bus.in_a;
                    alu_b_d = bus.in_b;
                    alu_s_d = S_FIRST;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    out_y_d     = bus.alu_y;
                    out_carry_d = bus.alu_carry;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                    out_zero_d  = (bus.alu_y == '0);
`endif
                    out_s_d     = alu_s_q;
                    out_last_d  = (alu_s_q == S_LAST);
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        state_d    = ST_IDLE;
                    end else begin
                        alu_s_d = alu_s_q + 3'd1;
                        cnt_d   = CNT_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= S_FIRST;
            out_valid_q <= 1'b0;
            out_s_q     <= 3'd0;
            out_y_q     <= '0;
            out_carry_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            out_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            out_valid_q <= out_valid_d;
            out_s_q     <= out_s_d;
            out_y_q     <= out_y_d;
            out_carry_q <= out_carry_d;
            out_last_q  <= out_last_d;
`ifdef ALU_SEQ_ZERO_FLAG_EN
            out_zero_q  <= out_zero_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_s     = alu_s_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = out_s_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_carry = out_carry_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = (state_q != ST_IDLE);
`ifdef ALU_SEQ_ZERO_FLAG_EN
    assign bus.out_zero  = out_zero_q;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: default sweep, single-op sweep, SETTLE=4 with a slow ALU,
// backpressure, ignored in_valid mid-sweep and reset mid-sweep.
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.WIDTH(8)) if0 ();
    alu_op_sequencer_if #(.WIDTH(8)) if1 ();
    alu_op_sequencer_if #(.WIDTH(8)) if2 ();

    alu_op_sequencer u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.master));
    alu_op_sequencer #(.OP_FIRST(0), .OP_LAST(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.master));
    alu_op_sequencer #(.SETTLE(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.master));

    // Reference ALU, returns {carry, y} using the team opcode map.
    function automatic logic [8:0] aluRef(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {a[7], a[6:0], 1'b0};
            default: return {a[0], 1'b0, a[7:1]};
        endcase
    endfunction

    assign {if0.alu_carry, if0.alu_y} = aluRef(if0.alu_a, if0.alu_b, if0.alu_s);
    assign {if1.alu_carry, if1.alu_y} = aluRef(if1.alu_a, if1.alu_b, if1.alu_s);

    // Slow ALU for the SETTLE=4 instance: output is scrambled until inputs have been stable for 3 edges.
    logic [18:0] in2_now;
    logic [18:0] in2_seen;
    logic [8:0]  ref2;
    int          age2 = 0;
    assign in2_now = {if2.alu_a, if2.alu_b, if2.alu_s};
    assign ref2    = aluRef(if2.alu_a, if2.alu_b, if2.alu_s);
    always @(posedge clk) begin
        if (in2_now !== in2_seen) begin
            in2_seen <= in2_now;
            age2     <= 0;
        end else if (age2 < 3) begin
            age2 <= age2 + 1;
        end
    end
    assign {if2.alu_carry, if2.alu_y} = ((in2_now === in2_seen) && (age2 >= 2)) ? ref2 : (ref2 ^ 9'h1A5);

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
    endtask

    function automatic logic isValid(input int which);
        case (which)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    function automatic logic isReady(input int which);
        case (which)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    task automatic driveIn(input int which, input logic v, input logic [7:0] a, input logic [7:0] b);
        case (which)
            0:       begin if0.in_valid = v; if0.in_a = a; if0.in_b = b; end
            1:       begin if1.in_valid = v; if1.in_a = a; if1.in_b = b; end
            default: begin if2.in_valid = v; if2.in_a = a; if2.in_b = b; end
        endcase
    endtask

    // Presents one operand pair and returns just after the accepting edge.
    task automatic applyStimulus(input int which, input logic [7:0] a, input logic [7:0] b);
        logic done;
        done = 1'b0;
        driveIn(which, 1'b1, a, b);
        for (int i = 0; i < 20 && !done; i++) begin
            if (isReady(which)) done = 1'b1;
            step();
        end
        driveIn(which, 1'b0, 8'd0, 8'd0);
        if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitValid(input int which, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (isValid(which)) begin
                seen = 1'b1;
                return;
            end
            step();
        end
        checkOutput("valid_timeout", 32'd0, 32'd1);
    endtask

    logic [7:0] exp_y1 [8] = '{8'd20, 8'd0, 8'd10, 8'd10, 8'd0, 8'd245, 8'd20, 8'd5};
    logic [7:0] exp_y2 [8] = '{8'h4B, 8'h2D, 8'h0C, 8'h3F, 8'h33, 8'hC3, 8'h78, 8'h1E};
    logic [7:0] exp_y5 [8] = '{8'd136, 8'd130, 8'd1, 8'd135, 8'd134, 8'd122, 8'd10, 8'd66};
    logic       exp_c5 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic seen;
        logic extra;
        logic held;
        int   lat;
        int   beats;
        int   prev_hs;

        driveIn(0, 1'b0, 8'd0, 8'd0);
        driveIn(1, 1'b0, 8'd0, 8'd0);
        driveIn(2, 1'b0, 8'd0, 8'd0);
        if0.out_ready = 1'b0;
        if1.out_ready = 1'b0;
        if2.out_ready = 1'b0;

        // Reset values
        step();
        step();
        checkOutput("rst_in_ready", if0.in_ready, 0);
        checkOutput("rst_busy", if0.busy, 0);
        checkOutput("rst_out_valid", if0.out_valid, 0);
        checkOutput("rst_alu_s", if0.alu_s, 0);
        checkOutput("rst_alu_a", if0.alu_a, 0);
        checkOutput("rst_out_y", if0.out_y, 0);
        rst_n = 1'b1;
        #1;
        checkOutput("rel_in_ready", if0.in_ready, 1);
        step();

        // Full default sweep with out_ready held high
        if0.out_ready = 1'b1;
        applyStimulus(0, 8'd10, 8'd10);
        checkOutput("t1_busy", if0.busy, 1);
        checkOutput("t1_in_ready", if0.in_ready, 0);
        checkOutput("t1_alu_a", if0.alu_a, 10);
        checkOutput("t1_alu_s", if0.alu_s, 0);
        lat = 0;
        while (!if0.out_valid && lat < 10) begin
            step();
            lat++;
        end
        checkOutput("t1_first_latency", lat, 1);
        for (int k = 0; k < 8; k++) begin
            waitValid(0, seen);
            if (!seen) break;
            checkOutput($sformatf("t1_s%0d_s", k), if0.out_s, k);
            checkOutput($sformatf("t1_s%0d_y", k), if0.out_y, exp_y1[k]);
            checkOutput($sformatf("t1_s%0d_c", k), if0.out_carry, 0);
            checkOutput($sformatf("t1_s%0d_last", k), if0.out_last, (k == 7) ? 1 : 0);
            step();
        end
        checkOutput("t1_done_busy", if0.busy, 0);
        checkOutput("t1_done_in_ready", if0.in_ready, 1);
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            extra |= if0.out_valid;
            step();
        end
        checkOutput("t1_no_extra_beat", extra, 0);

        // Backpressure on s=3 and an in_valid pulse mid-sweep
        applyStimulus(0, 8'h3C, 8'h0F);
        beats = 0;
        held  = 1'b0;
        for (int g = 0; g < 200 && beats < 8; g++) begin
            waitValid(0, seen);
            if (!seen) break;
            checkOutput($sformatf("t2_beat%0d_s", beats), if0.out_s, beats);
            checkOutput($sformatf("t2_beat%0d_y", beats), if0.out_y, exp_y2[beats]);
            if (if0.out_s == 3'd3 && !held) begin
                held = 1'b1;
                if0.out_ready = 1'b0;
                for (int j = 0; j < 5; j++) begin
                    step();
                    checkOutput("t2_hold_valid", if0.out_valid, 1);
                    checkOutput("t2_hold_y", if0.out_y, 8'h3F);
                    checkOutput("t2_hold_s", if0.out_s, 3);
                    checkOutput("t2_hold_alu_s", if0.alu_s, 3);
                end
                if0.out_ready = 1'b1;
            end
            step();
            beats++;
            if (beats == 2) begin
                driveIn(0, 1'b1, 8'd1, 8'd1);
                step();
                driveIn(0, 1'b0, 8'd0, 8'd0);
                checkOutput("t2_ignore_alu_a", if0.alu_a, 8'h3C);
                checkOutput("t2_ignore_alu_b", if0.alu_b, 8'h0F);
            end
        end
        checkOutput("t2_beats", beats, 8);
        extra = 1'b0;
        for (int i = 0; i < 4; i++) begin
            extra |= if0.out_valid;
            step();
        end
        checkOutput("t2_no_extra_beat", extra, 0);
        checkOutput("t2_idle_busy", if0.busy, 0);

        // Reset while beat s=3 is being offered
        applyStimulus(0, 8'd10, 8'd10);
        for (int k = 0; k < 3; k++) begin
            waitValid(0, seen);
            step();
        end
        waitValid(0, seen);
        checkOutput("t3_pre_s", if0.out_s, 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t3_rst_out_valid", if0.out_valid, 0);
        checkOutput("t3_rst_busy", if0.busy, 0);
        checkOutput("t3_rst_out_s", if0.out_s, 0);
        checkOutput("t3_rst_out_y", if0.out_y, 0);
        checkOutput("t3_rst_alu_s", if0.alu_s, 0);
        checkOutput("t3_rst_in_ready", if0.in_ready, 0);
        step();
        rst_n = 1'b1;
        applyStimulus(0, 8'd200, 8'd100);
        waitValid(0, seen);
        checkOutput("t3_restart_s", if0.out_s, 0);
        checkOutput("t3_restart_y", if0.out_y, 44);
        checkOutput("t3_restart_c", if0.out_carry, 1);
        for (int g = 0; g < 60; g++) begin
            if (if0.out_valid && if0.out_last) begin
                step();
                break;
            end
            step();
        end
        checkOutput("t3_drain_busy", if0.busy, 0);

        // Single-opcode sweep
        if1.out_ready = 1'b1;
        applyStimulus(1, 8'd200, 8'd100);
        waitValid(1, seen);
        checkOutput("t4_s", if1.out_s, 0);
        checkOutput("t4_y", if1.out_y, 44);
        checkOutput("t4_c", if1.out_carry, 1);
        checkOutput("t4_last", if1.out_last, 1);
        step();
        checkOutput("t4_after_valid", if1.out_valid, 0);
        checkOutput("t4_after_busy", if1.busy, 0);
        checkOutput("t4_after_in_ready", if1.in_ready, 1);

        // SETTLE=4 with a slow ALU
        if2.out_ready = 1'b1;
        applyStimulus(2, 8'h85, 8'h03);
        lat = 0;
        while (!if2.out_valid && lat < 20) begin
            step();
            lat++;
        end
        checkOutput("t5_first_latency", lat, 4);
        prev_hs = 0;
        for (int k = 0; k < 8; k++) begin
            waitValid(2, seen);
            if (!seen) break;
            checkOutput($sformatf("t5_s%0d_s", k), if2.out_s, k);
            checkOutput($sformatf("t5_s%0d_y", k), if2.out_y, exp_y5[k]);
            checkOutput($sformatf("t5_s%0d_c", k), if2.out_carry, exp_c5[k]);
            if (k > 0) checkOutput($sformatf("t5_s%0d_period", k), cycle - prev_hs, 5);
            prev_hs = cycle;
            step();
        end
        checkOutput("t5_done_busy", if2.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
